// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared FSM encodings and PC defaults for the fetch controller
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_MISS = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_t;

    localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
    localparam logic [15:0] FETCH_PC_STEP  = 16'h0002;

endpackage

// File: rtl/addsub_16bit.sv
// rtl/addsub_16bit.sv - 16-bit wrapping adder/subtractor
module addsub_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        is_sub,
    output logic [15:0] result
);

    assign result = is_sub ? (a - b) : (a + b);

endmodule

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating 16-bit event counter with enable
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer with miss, stall, redirect and halt handling
// FETCH_PERF_CNT_EN adds miss/stall/redirect performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [15:0] PC_STEP  = FETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        hlt_dec,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_miss_cyc,
    output logic [15:0] perf_stall_cyc,
    output logic [15:0] perf_redirect
`endif
);

    fetch_state_t state, state_nxt;
    logic [15:0]  pc_nxt;
    logic [15:0]  redir_tgt, redir_tgt_nxt;
    logic         redir_pend, redir_pend_nxt;
    logic         req_c, if_valid_c, flush_c;

    addsub_16bit u_pc_add (
        .a      (pc),
        .b      (PC_STEP),
        .is_sub (1'b0),
        .result (pc_plus2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            redir_tgt  <= 16'h0000;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            redir_tgt  <= redir_tgt_nxt;
            redir_pend <= redir_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        redir_tgt_nxt  = redir_tgt;
        redir_pend_nxt = redir_pend;
        req_c          = 1'b0;
        if_valid_c     = 1'b0;
        flush_c        = 1'b0;
        case (state)
            ST_RUN: begin
                req_c = 1'b1;
                if (br_taken) begin
                    pc_nxt  = br_target;
                    flush_c = 1'b1;
                end else if (hlt_dec) begin
                    state_nxt = ST_HALT;
                    flush_c   = 1'b1;
                end else if (stall) begin
                    if_valid_c = imem_ready;
                end else if (!imem_ready) begin
                    state_nxt = ST_MISS;
                end else begin
                    pc_nxt     = pc_plus2;
                    if_valid_c = 1'b1;
                end
            end
            ST_MISS: begin
                req_c = 1'b1;
                if (br_taken) begin
                    flush_c = 1'b1;
                    // A redirect landing on the completing cycle needs no parking.
                    if (imem_ready) begin
                        pc_nxt         = br_target;
                        redir_pend_nxt = 1'b0;
                        state_nxt      = ST_RUN;
                    end else begin
                        redir_tgt_nxt  = br_target;
                        redir_pend_nxt = 1'b1;
                    end
                end else if (hlt_dec) begin
                    state_nxt      = ST_HALT;
                    redir_pend_nxt = 1'b0;
                end else if (imem_ready) begin
                    state_nxt = ST_RUN;
                    if (redir_pend) begin
                        pc_nxt         = redir_tgt;
                        redir_pend_nxt = 1'b0;
                    end else begin
                        if_valid_c = 1'b1;
                        if (!stall) pc_nxt = pc_plus2;
                    end
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is asserted.
    assign imem_req   = rst_n & req_c;
    assign if_valid   = rst_n & if_valid_c;
    assign flush_ifid = rst_n & flush_c;
    assign halted     = (state == ST_HALT);
    assign imem_addr  = pc;

`ifdef FETCH_PERF_CNT_EN
    logic miss_en, stall_en, redirect_en;

    assign miss_en     = (state == ST_MISS);
    assign stall_en    = stall && (state != ST_HALT);
    assign redirect_en = br_taken && (state != ST_HALT);

    fetch_perf_cnt u_cnt_miss (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (miss_en),
        .count (perf_miss_cyc)
    );

    fetch_perf_cnt u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .count (perf_stall_cyc)
    );

    fetch_perf_cnt u_cnt_redirect (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (redirect_en),
        .count (perf_redirect)
    );
`endif

endmodule
